// File: rtl/train_dispatch_if.sv
// ---------------------------------------------------------------------------
// train_dispatch_if
//   Bundles the script input and the departure-frame output of
//   train_dispatch.
//   Optional: define TRAIN_DISPATCH_ERRCODE_EN to add err_code.
//
//   in_valid  script frame valid (header beat followed by op beats)
//   num       car count N, meaningful on the header beat only
//   op        1 = push next arriving car, 0 = pop stack top
//   out_valid departure frame / error beat valid
//   data      N, then departing car numbers
//   err       single error beat marker
//   err_code  (optional) error reason on the error beat
//
//   master : script producer / frame consumer
//   slave  : the dispatcher itself
// ---------------------------------------------------------------------------
interface train_dispatch_if;
    logic       in_valid;
    logic [3:0] num;
    logic       op;
    logic       out_valid;
    logic [3:0] data;
    logic       err;
`ifdef TRAIN_DISPATCH_ERRCODE_EN
    logic [2:0] err_code;
`endif

    modport master (
        output in_valid, num, op,
        input  out_valid, data, err
`ifdef TRAIN_DISPATCH_ERRCODE_EN
        , input err_code
`endif
    );

    modport slave (
        input  in_valid, num, op,
        output out_valid, data, err
`ifdef TRAIN_DISPATCH_ERRCODE_EN
        , output err_code
`endif
    );
endinterface

// File: rtl/train_dispatch.sv
// ---------------------------------------------------------------------------
// train_dispatch
//   Replays a push/pop script on a 10-deep stack fed by cars 1..N in order,
//   then emits the departure frame: N followed by the N departing cars.
//   A bad script yields one error beat instead of a frame.
//   Optional: define TRAIN_DISPATCH_ERRCODE_EN to drive bus.err_code
//   (1 bad N, 2 pop empty, 3 push overflow, 4 incomplete).
//
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    train_dispatch_if.slave (script in, frame out)
// ---------------------------------------------------------------------------
module train_dispatch (
    input  logic              clk,
    input  logic              rst_n,
    train_dispatch_if.slave   bus
);
    localparam int DEPTH = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_CHECK = 3'd2,
        S_SEND  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t     state_reg, state_next;

    logic [3:0] n_reg;
    logic [3:0] next_car_reg;
    logic [3:0] pop_cnt_reg;
    logic [3:0] sp_reg;
    logic [3:0] beat_reg;
    logic [2:0] code_reg;

    logic [3:0] stack_mem [0:DEPTH-1];
    logic [3:0] dep_mem   [0:DEPTH-1];

    logic       out_valid_reg, out_valid_next;
    logic [3:0] data_reg, data_next;
    logic       err_reg, err_next;
    logic [2:0] err_code_reg, err_code_next;

    // ------------------------------------------------------------------
    // Per-beat decode
    // ------------------------------------------------------------------
    logic       header_en;
    logic       recv_op;
    logic       push_ok, push_bad, pop_ok, pop_bad;
    logic       incomplete;
    logic       any_err;
    logic [3:0] sp_m1;
    logic [3:0] beat_m1;
    logic [3:0] top;

    assign header_en = (state_reg == S_IDLE) && bus.in_valid;
    // Ops are only acted on while no error is latched; the first error wins.
    assign recv_op   = (state_reg == S_RECV) && bus.in_valid && (code_reg == 3'd0);
    assign push_ok   = recv_op &&  bus.op && (next_car_reg <= n_reg);
    assign push_bad  = recv_op &&  bus.op && (next_car_reg >  n_reg);
    assign pop_ok    = recv_op && !bus.op && (sp_reg != 4'd0);
    assign pop_bad   = recv_op && !bus.op && (sp_reg == 4'd0);

    assign sp_m1     = sp_reg - 4'd1;
    assign beat_m1   = beat_reg - 4'd1;
    assign top       = stack_mem[sp_m1];

    // Every car must have arrived and left; compared in 5 bits so N+1 never wraps.
    assign incomplete = (code_reg == 3'd0) &&
                        (({1'b0, next_car_reg} != ({1'b0, n_reg} + 5'd1)) ||
                         (sp_reg != 4'd0));
    assign any_err    = (code_reg != 3'd0) || incomplete;

    // ------------------------------------------------------------------
    // Stack and departure buffer storage, one register per slot
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stack_mem[gi] <= 4'd0;
                end else if (push_ok && (sp_reg == 4'(gi))) begin
                    stack_mem[gi] <= next_car_reg;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dep_mem[gi] <= 4'd0;
                end else if (pop_ok && (pop_cnt_reg == 4'(gi))) begin
                    dep_mem[gi] <= top;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters and error code
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg        <= 4'd0;
            next_car_reg <= 4'd0;
            pop_cnt_reg  <= 4'd0;
            sp_reg       <= 4'd0;
            beat_reg     <= 4'd0;
            code_reg     <= 3'd0;
        end else begin
            if (header_en) begin
                n_reg        <= bus.num;
                sp_reg       <= 4'd0;
                next_car_reg <= 4'd1;
                pop_cnt_reg  <= 4'd0;
                code_reg     <= ((bus.num == 4'd0) || (bus.num > 4'd10)) ? 3'd1 : 3'd0;
            end
            if (push_ok) begin
                sp_reg       <= sp_reg + 4'd1;
                next_car_reg <= next_car_reg + 4'd1;
            end
            if (push_bad) begin
                code_reg <= 3'd3;
            end
            if (pop_ok) begin
                sp_reg      <= sp_m1;
                pop_cnt_reg <= pop_cnt_reg + 4'd1;
            end
            if (pop_bad) begin
                code_reg <= 3'd2;
            end
            if ((state_reg == S_CHECK) && incomplete) begin
                code_reg <= 3'd4;
            end
            if (state_reg == S_CHECK) begin
                beat_reg <= 4'd0;
            end else if (state_reg == S_SEND) begin
                beat_reg <= beat_reg + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.in_valid)  state_next = S_RECV;
            S_RECV:  if (!bus.in_valid) state_next = S_CHECK;
            S_CHECK: state_next = any_err ? S_ERR : S_SEND;
            // Beat 0 carries N, beats 1..N the cars: leave after beat N.
            S_SEND:  if (beat_reg == n_reg) state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM: outputs (computed one cycle ahead, then registered)
    always_comb begin
        out_valid_next = 1'b0;
        data_next      = 4'd0;
        err_next       = 1'b0;
        err_code_next  = 3'd0;
        case (state_reg)
            S_SEND: begin
                out_valid_next = 1'b1;
                data_next      = (beat_reg == 4'd0) ? n_reg : dep_mem[beat_m1];
            end
            S_ERR: begin
                out_valid_next = 1'b1;
                err_next       = 1'b1;
                err_code_next  = code_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            data_reg      <= 4'd0;
            err_reg       <= 1'b0;
            err_code_reg  <= 3'd0;
        end else begin
            out_valid_reg <= out_valid_next;
            data_reg      <= data_next;
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.data      = data_reg;
    assign bus.err       = err_reg;
`ifdef TRAIN_DISPATCH_ERRCODE_EN
    assign bus.err_code  = err_code_reg;
`else
    // Code is still latched internally; without the port it has no reader.
    logic unused_code;
    assign unused_code = ^err_code_reg;
`endif
endmodule
